// File: rtl/qcl_bram_arb_pkg.sv
// Shared types and width helpers for the arbitrated simple-dual-port BRAM front end.
package qcl_bram_arb_pkg;

  // Widest data / id a response descriptor can carry.
  localparam int resp_data_max_lp = 32;
  localparam int resp_id_max_lp   = 8;

  // Read response descriptor: returned data plus the id of the client that owns it.
  typedef struct packed {
    logic [resp_data_max_lp-1:0] data;
    logic [resp_id_max_lp-1:0]   id;
  } qcl_bram_resp_t;

  // clog2 that never returns 0, so a single-entry index still gets one bit.
  function automatic int safe_clog2(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/qcl_bram_sdp_1clk_1r1w.sv
// Single-clock simple-dual-port RAM, registered read, read-before-write on address collision.
module qcl_bram_sdp_1clk_1r1w
  import qcl_bram_arb_pkg::*;
#(
  parameter  int    width_p       = 8,
  parameter  int    els_p         = 16,
  parameter  string init_file_p   = "",
  localparam int    addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] r_data_q;

  // Preloading is left to the vendor memory flow; refuse a file rather than silently ignore it.
  if (init_file_p != "") begin : g_init_unsupported
    $error("qcl_bram_sdp_1clk_1r1w: init_file_p preload is not supported by this model");
  end

  // Array write port.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  // Registered read; holds its value whenever no read is issued.
  always_ff @(posedge clk_i) begin
    if (r_v_i) begin
      r_data_q <= mem_q[r_addr_i];
    end
  end

  assign r_data_o = r_data_q;

endmodule

// File: rtl/qcl_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted client.
module qcl_rr_arb
  import qcl_bram_arb_pkg::*;
#(
  parameter  int num_clients_p = 4,
  localparam int id_width_lp   = safe_clog2(num_clients_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [num_clients_p-1:0] v_i,
  input  logic                     en_i,
  output logic [num_clients_p-1:0] yumi_o,
  output logic [id_width_lp-1:0]   id_o
);

  logic [id_width_lp-1:0]   last_q, last_d;
  logic [num_clients_p-1:0] yumi_s;
  logic [id_width_lp-1:0]   id_s;
  logic                     found_s;

  // Pick the first requester after last_q (wrapping); nothing is granted in reset or when disabled.
  always_comb begin
    int sum;
    logic [id_width_lp-1:0] cand;
    yumi_s  = '0;
    id_s    = '0;
    found_s = 1'b0;
    for (int i = 1; i <= num_clients_p; i++) begin
      sum = int'(last_q) + i;
      if (sum >= num_clients_p) begin
        sum = sum - num_clients_p;
      end else begin
        sum = sum;
      end
      cand = sum[id_width_lp-1:0];
      if (en_i && !reset_i && !found_s && v_i[cand]) begin
        found_s      = 1'b1;
        yumi_s[cand] = 1'b1;
        id_s         = cand;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      last_d = id_s;
    end else begin
      last_d = last_q;
    end
  end

  // Priority pointer; resets to the highest index so client 0 wins first.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= id_width_lp'(num_clients_p - 1);
    end else begin
      last_q <= last_d;
    end
  end

  assign yumi_o = yumi_s;
  assign id_o   = id_s;

endmodule

// File: rtl/qcl_bram_sdp_arb.sv
// Arbitrated front end sharing one BRAM write and one read port among several clients.
module qcl_bram_sdp_arb
  import qcl_bram_arb_pkg::*;
#(
  parameter  int    width_p       = 8,
  parameter  int    els_p         = 16,
  parameter  int    num_clients_p = 4,
  parameter  string init_file_p   = "",
  localparam int    addr_width_lp = safe_clog2(els_p),
  localparam int    id_width_lp   = safe_clog2(num_clients_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_clients_p-1:0]               w_v_i,
  input  logic [num_clients_p*addr_width_lp-1:0] w_addr_i,
  input  logic [num_clients_p*width_p-1:0]       w_data_i,
  output logic [num_clients_p-1:0]               w_yumi_o,
  input  logic [num_clients_p-1:0]               r_v_i,
  input  logic [num_clients_p*addr_width_lp-1:0] r_addr_i,
  output logic [num_clients_p-1:0]               r_yumi_o,
  output logic                                   r_v_o,
  output logic [width_p-1:0]                     r_data_o,
  output logic [id_width_lp-1:0]                 r_id_o,
  input  logic                                   r_ready_i
);

  logic                     resp_v_q, resp_v_d;
  logic [id_width_lp-1:0]   id_q, id_d;
  logic                     launch_ok_s;
  logic [num_clients_p-1:0] w_yumi_s, r_yumi_s;
  logic [id_width_lp-1:0]   w_id_s, r_id_s;
  logic                     bram_w_v_s, bram_r_v_s;

  // A new read may launch only if the response slot is empty or being drained.
  assign launch_ok_s = !resp_v_q || r_ready_i;

  qcl_rr_arb #(.num_clients_p(num_clients_p)) w_arb (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (w_v_i),
    .en_i   (1'b1),
    .yumi_o (w_yumi_s),
    .id_o   (w_id_s)
  );

  qcl_rr_arb #(.num_clients_p(num_clients_p)) r_arb (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (r_v_i),
    .en_i   (launch_ok_s),
    .yumi_o (r_yumi_s),
    .id_o   (r_id_s)
  );

  // The arbiters already suppress grants in reset, so any grant drives the BRAM port.
  assign bram_w_v_s = |w_yumi_s;
  assign bram_r_v_s = |r_yumi_s;

  qcl_bram_sdp_1clk_1r1w #(
    .width_p    (width_p),
    .els_p      (els_p),
    .init_file_p(init_file_p)
  ) bram (
    .clk_i   (clk_i),
    .w_v_i   (bram_w_v_s),
    .w_addr_i(w_addr_i[w_id_s*addr_width_lp +: addr_width_lp]),
    .w_data_i(w_data_i[w_id_s*width_p +: width_p]),
    .r_v_i   (bram_r_v_s),
    .r_addr_i(r_addr_i[r_id_s*addr_width_lp +: addr_width_lp]),
    .r_data_o(r_data_o)
  );

  // Response slot next state: a launch fills it, a consumer handshake empties it.
  always_comb begin
    resp_v_d = resp_v_q;
    id_d     = id_q;
    if (bram_r_v_s) begin
      resp_v_d = 1'b1;
      id_d     = r_id_s;
    end else if (r_ready_i) begin
      resp_v_d = 1'b0;
    end else begin
      resp_v_d = resp_v_q;
    end
  end

  // Response slot register; reset drops any in-flight or stalled response.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_v_q <= 1'b0;
      id_q     <= '0;
    end else begin
      resp_v_q <= resp_v_d;
      id_q     <= id_d;
    end
  end

  assign w_yumi_o = w_yumi_s;
  assign r_yumi_o = r_yumi_s;
  assign r_v_o    = resp_v_q;
  assign r_id_o   = id_q;

endmodule

// File: tb/tb_qcl_bram_sdp_arb.sv
// Directed bench for qcl_bram_sdp_arb with 4 clients, 16 x 8-bit BRAM.
module tb_qcl_bram_sdp_arb;
  import qcl_bram_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic            clk;
  logic            reset_i;
  logic [N-1:0]    w_v, r_v, w_yumi, r_yumi;
  logic [N*AW-1:0] w_addr, r_addr;
  logic [N*DW-1:0] w_data;
  logic            r_v_o, r_ready;
  logic [DW-1:0]   r_data_o;
  logic [1:0]      r_id_o;

  int checks_cnt = 0;
  int errors_cnt = 0;

  qcl_bram_sdp_arb #(.width_p(DW), .els_p(16), .num_clients_p(N), .init_file_p("")) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .w_v_i    (w_v),
    .w_addr_i (w_addr),
    .w_data_i (w_data),
    .w_yumi_o (w_yumi),
    .r_v_i    (r_v),
    .r_addr_i (r_addr),
    .r_yumi_o (r_yumi),
    .r_v_o    (r_v_o),
    .r_data_o (r_data_o),
    .r_id_o   (r_id_o),
    .r_ready_i(r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_resp(input string tag, input qcl_bram_resp_t e);
    chk({tag, "_v"}, 32'(r_v_o), 32'd1);
    chk({tag, "_data"}, 32'(r_data_o), e.data);
    chk({tag, "_id"}, 32'(r_id_o), 32'(e.id));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int n, input logic [3:0] a, input logic [7:0] d);
    w_v[n] = 1'b1;
    w_addr[n*AW +: AW] = a;
    w_data[n*DW +: DW] = d;
  endtask

  task automatic rd(input int n, input logic [3:0] a);
    r_v[n] = 1'b1;
    r_addr[n*AW +: AW] = a;
  endtask

  task automatic clear();
    w_v = 4'b0000;
    r_v = 4'b0000;
  endtask

  // Grants must be one-hot or idle on every cycle.
  always @(negedge clk) begin
    chk("w_yumi_onehot0", 32'($onehot0(w_yumi)), 32'd1);
    chk("r_yumi_onehot0", 32'($onehot0(r_yumi)), 32'd1);
  end

  initial begin
    reset_i = 1'b1;
    r_ready = 1'b1;
    w_v = 4'b0000; r_v = 4'b0000;
    w_addr = '0; w_data = '0; r_addr = '0;
    for (int n = 0; n < N; n++) begin
      wr(n, 4'(8 + n), 8'(8'h30 + n));
      rd(n, 4'(n));
    end

    // Reset: requests present but no grants.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_w_yumi", 32'(w_yumi), 32'h0);
    chk("rst_r_yumi", 32'(r_yumi), 32'h0);
    step();
    reset_i = 1'b0;
    r_v = 4'b0000;

    // All four clients write every cycle: 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("post_rst_r_v", 32'(r_v_o), 32'd0);
        chk("post_rst_r_id", 32'(r_id_o), 32'd0);
      end
      chk($sformatf("w_rr_%0d", k), 32'(w_yumi), 32'(4'b0001 << (k % 4)));
      chk($sformatf("w_onehot_%0d", k), 32'($onehot(w_yumi)), 32'd1);
      step();
    end
    clear();

    // Client 2 writes addr5=A5, then reads it back.
    wr(2, 4'd5, 8'hA5);
    @(negedge clk); chk("t2_w_yumi", 32'(w_yumi), 32'b0100);
    step(); clear(); rd(2, 4'd5);
    @(negedge clk); chk("t2_r_yumi", 32'(r_yumi), 32'b0100);
    step(); clear();
    @(negedge clk); expect_resp("t2_resp", '{data: 32'hA5, id: 8'd2});
    chk("t2_r_yumi_idle", 32'(r_yumi), 32'h0);
    step();
    @(negedge clk); chk("t2_idle_v", 32'(r_v_o), 32'd0);
    step();

    // Same-cycle read/write of addr3 returns the old value.
    wr(0, 4'd3, 8'h11);
    @(negedge clk); chk("t3_w0", 32'(w_yumi), 32'b0001);
    step(); clear(); wr(1, 4'd3, 8'h22); rd(0, 4'd3);
    @(negedge clk); chk("t3_w1", 32'(w_yumi), 32'b0010); chk("t3_r0", 32'(r_yumi), 32'b0001);
    step(); clear(); rd(3, 4'd3);
    @(negedge clk); expect_resp("t3_old", '{data: 32'h11, id: 8'd0});
    chk("t3_r3", 32'(r_yumi), 32'b1000);
    step(); clear();
    @(negedge clk); expect_resp("t3_new", '{data: 32'h22, id: 8'd3});
    step();
    @(negedge clk); chk("t3_idle_v", 32'(r_v_o), 32'd0);
    step();

    // Clients 0 and 1 read back to back: alternating ids, no bubbles.
    rd(0, 4'd8); rd(1, 4'd9);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t4_yumi_%0d", k), 32'(r_yumi), (k % 2 == 0) ? 32'b0001 : 32'b0010);
      if (k > 0) begin
        expect_resp($sformatf("t4_resp_%0d", k - 1),
                    '{data: ((k - 1) % 2 == 0) ? 32'h30 : 32'h31, id: 8'((k - 1) % 2)});
      end
      step();
    end
    clear();
    @(negedge clk); expect_resp("t4_resp_7", '{data: 32'h31, id: 8'd1});
    step();
    @(negedge clk); chk("t4_idle_v", 32'(r_v_o), 32'd0);
    step();

    // Backpressure: three-cycle stall holds the response and blocks grants.
    rd(2, 4'd10); rd(3, 4'd11);
    @(negedge clk); chk("t5_yumi_s0", 32'(r_yumi), 32'b0100);
    step();
    r_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t5_stall_yumi_%0d", k), 32'(r_yumi), 32'h0);
      expect_resp($sformatf("t5_stall_%0d", k), '{data: 32'h32, id: 8'd2});
      step();
    end
    r_ready = 1'b1;
    @(negedge clk); chk("t5_yumi_s4", 32'(r_yumi), 32'b1000);
    expect_resp("t5_drain", '{data: 32'h32, id: 8'd2});
    step(); clear();
    @(negedge clk); expect_resp("t5_next", '{data: 32'h33, id: 8'd3});
    step();
    @(negedge clk); chk("t5_idle_v", 32'(r_v_o), 32'd0);
    step();

    // Reset while a response is stalled: response dropped, priority back to client 0.
    rd(1, 4'd9);
    @(negedge clk); chk("t6_yumi_u0", 32'(r_yumi), 32'b0010);
    step(); clear(); r_ready = 1'b0; reset_i = 1'b1;
    @(negedge clk); chk("t6_yumi_rst", 32'(r_yumi), 32'h0);
    expect_resp("t6_stalled", '{data: 32'h31, id: 8'd1});
    step(); reset_i = 1'b0; r_ready = 1'b1; rd(0, 4'd8); rd(3, 4'd11);
    @(negedge clk);
    chk("t6_r_v_after_rst", 32'(r_v_o), 32'd0);
    chk("t6_r_id_after_rst", 32'(r_id_o), 32'd0);
    chk("t6_first_grant", 32'(r_yumi), 32'b0001);
    step(); clear();
    @(negedge clk); expect_resp("t6_resp", '{data: 32'h30, id: 8'd0});
    step();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
